// File: rtl/mem_store_buffer_pkg.sv
// Shared constants and helpers for the MEM-stage store buffer.
// Feature macro STORE_FWD_EN (see mem_store_buffer.sv) is not referenced here.
package mem_store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int WEN_W    = 4;
    localparam int DATA_W   = 32;

    // Bit positions inside the one-hot {sb,sh,sw} store opcode
    localparam int OP_SB = 2;
    localparam int OP_SH = 1;
    localparam int OP_SW = 0;

    function automatic logic lane_hit(
        input logic [WEN_W-1:0] wen,
        input logic [WEN_W-1:0] be
    );
        return |(wen & be);
    endfunction

    function automatic logic lane_cover(
        input logic [WEN_W-1:0] wen,
        input logic [WEN_W-1:0] be
    );
        return (wen & be) == be;
    endfunction

endpackage

// File: rtl/mem_store_buffer_lane_gen.sv
// Store lane generator: one-hot op + low address bits -> byte strobes,
// lane-replicated write data and misalignment flag.
module store_lane_gen
    import mem_store_buffer_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [WEN_W-1:0]  wen_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misal_o,
    output logic              legal_o
);

    always_comb begin
        wen_o   = '0;
        wdata_o = '0;
        misal_o = 1'b0;
        legal_o = 1'b1;
        unique case (1'b1)
            op_i[OP_SB]: begin
                wen_o   = 4'b0001 << addr_i;
                wdata_o = {4{data_i[7:0]}};
            end
            op_i[OP_SH]: begin
                wen_o   = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{data_i[15:0]}};
                misal_o = addr_i[0];
            end
            op_i[OP_SW]: begin
                wen_o   = 4'b1111;
                wdata_o = data_i;
                misal_o = |addr_i;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: queues committed stores and drains them to the data SRAM.
// Optional store-to-load forwarding is built when STORE_FWD_EN is defined.
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_op,
    input  logic [AW-1:0]     st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              excp_ades,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_addr,
    input  logic [WEN_W-1:0]  ld_be,
    output logic              stallreq,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
    output logic              data_sram_en,
    output logic [WEN_W-1:0]  data_sram_wen,
    output logic [AW-1:0]     data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_gnt,
    output logic              sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]        wptr_q, wptr_d;
    logic [PW:0]        rptr_q, rptr_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               excp_q;
    logic [AW-3:0]      addr_q  [DEPTH];
    logic [WEN_W-1:0]   wen_q   [DEPTH];
    logic [DATA_W-1:0]  wdata_q [DEPTH];

    logic [WEN_W-1:0]   lg_wen;
    logic [DATA_W-1:0]  lg_wdata;
    logic               lg_misal;
    logic               lg_legal;
    logic               full;
    logic               empty;
    logic               accept;
    logic               enq;
    logic               deq;
    logic [PW-1:0]      widx;
    logic [PW-1:0]      ridx;
    logic [DEPTH-1:0]   match;
    logic               unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];

    store_lane_gen u_lane_gen (
        .op_i    (st_op),
        .addr_i  (st_addr[1:0]),
        .data_i  (st_data),
        .wen_o   (lg_wen),
        .wdata_o (lg_wdata),
        .misal_o (lg_misal),
        .legal_o (lg_legal)
    );

    assign widx  = wptr_q[PW-1:0];
    assign ridx  = rptr_q[PW-1:0];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (widx == ridx);

    // Ready depends only on registered occupancy, never on a same-cycle drain
    assign st_ready = ~full;
    assign sb_empty = empty;
    assign accept   = st_valid & st_ready;
    assign enq      = accept & lg_legal & ~lg_misal;

    assign data_sram_en    = ~empty & ~ld_valid;
    assign data_sram_wen   = data_sram_en ? wen_q[ridx] : '0;
    assign data_sram_addr  = {addr_q[ridx], 2'b00};
    assign data_sram_wdata = wdata_q[ridx];
    assign deq             = data_sram_en & data_sram_gnt;
    assign excp_ades       = excp_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        if (deq) begin
            valid_d[ridx] = 1'b0;
            rptr_d        = rptr_q + PTR_ONE;
        end
        if (enq) begin
            valid_d[widx] = 1'b1;
            wptr_d        = wptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
            excp_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            excp_q  <= accept & lg_legal & lg_misal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wen_q[i]   <= '0;
                wdata_q[i] <= '0;
            end
        end else if (enq) begin
            addr_q[widx]  <= st_addr[AW-1:2];
            wen_q[widx]   <= lg_wen;
            wdata_q[widx] <= lg_wdata;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i]
                     && (addr_q[i] == ld_addr[AW-1:2])
                     && lane_hit(wen_q[i], ld_be);
        end
    end

`ifdef STORE_FWD_EN
    logic [PW-1:0] yng_idx;
    logic [PW-1:0] scan_idx;
    logic          hit;
    logic          part_acc;
    logic          older_part;
    logic          fwd_ok;

    // Walk oldest to youngest; an older partial overlap blocks forwarding
    always_comb begin
        yng_idx    = '0;
        scan_idx   = '0;
        hit        = 1'b0;
        part_acc   = 1'b0;
        older_part = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = ridx + k[PW-1:0];
            if (match[scan_idx]) begin
                hit        = 1'b1;
                yng_idx    = scan_idx;
                older_part = part_acc;
                part_acc   = part_acc | ~lane_cover(wen_q[scan_idx], ld_be);
            end
        end
        fwd_ok = hit && lane_cover(wen_q[yng_idx], ld_be) && !older_part;
    end

    assign stallreq  = ld_valid & (|match) & ~fwd_ok;
    assign fwd_valid = ld_valid & fwd_ok;
    assign fwd_data  = fwd_valid ? wdata_q[yng_idx] : '0;
`else
    assign stallreq  = ld_valid & (|match);
    assign fwd_valid = 1'b0;
    assign fwd_data  = '0;
`endif

endmodule
